// File: rtl/uart_avalon_master_bridge.sv
// Avalon-MM slave to 8N1 UART bridge: each read/write becomes an 8-byte request frame, completed by a 4-byte reply.
// Latency: 1 + 80*DIVIDER + reply time + 1 cycles; waitrequest drops for exactly one cycle (DONE).
// Backpressure: s0_waitrequest held high for the whole transfer; requests are sampled only in IDLE.
// Ports: clk/reset (sync, active high); s0_address/s0_read/s0_write/s0_writedata in, s0_readdata/s0_waitrequest out;
//        tx_out serial out (idle high); rx_in async serial in; timeout_err sticky reply-timeout flag.
module uart_avalon_master_bridge #(
  parameter int DIVIDER = 217,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s0_address,
  input  logic        s0_read,
  input  logic        s0_write,
  input  logic [31:0] s0_writedata,
  output logic [31:0] s0_readdata,
  output logic        s0_waitrequest,
  output logic        tx_out,
  input  logic        rx_in,
  output logic        timeout_err
);
  localparam int DW = $clog2(DIVIDER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDER - 1);
  // Preload so the first sample lands DIVIDER/2 cycles after the detected falling edge.
  localparam logic [DW-1:0] RX_INIT  = DW'(DIVIDER - DIVIDER / 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [63:0]     frame_q, frame_d;
  logic [9:0]      tx_sh_q, tx_sh_d;
  logic            tx_q, tx_d;
  logic [DW-1:0]   tx_div_q, tx_div_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [2:0]      tx_byte_q, tx_byte_d;
  logic [31:0]     reply_q, reply_d;
  logic [1:0]      rcnt_q, rcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            terr_q, terr_d;
  logic            rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic            rx_busy_q, rx_busy_d;
  logic [DW-1:0]   rx_div_q, rx_div_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            rx_byte_vld;

  // RX deserializer: free running in every state so it stays aligned to the line.
  always_comb begin
    rx_s1_d     = rx_in;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    rx_busy_d   = rx_busy_q;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_byte_vld = 1'b0;
    if (!rx_busy_q) begin
      if (rx_prev_q && !rx_s2_q) begin
        rx_busy_d = 1'b1;
        rx_div_d  = RX_INIT;
        rx_bit_d  = 4'd0;
      end
    end else if (rx_div_q == DIV_LAST) begin
      rx_div_d = '0;
      if (rx_bit_q == 4'd0) begin
        // Start bit reads high at mid-bit: treat as a glitch.
        if (rx_s2_q) rx_busy_d = 1'b0;
        else         rx_bit_d  = 4'd1;
      end else if (rx_bit_q == 4'd9) begin
        rx_busy_d   = 1'b0;
        rx_byte_vld = rx_s2_q;  // stop bit low = framing error, byte dropped
      end else begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 4'd1;
      end
    end else begin
      rx_div_d = rx_div_q + DW'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    frame_d        = frame_q;
    tx_sh_d        = tx_sh_q;
    tx_div_d       = tx_div_q;
    tx_bit_d       = tx_bit_q;
    tx_byte_d      = tx_byte_q;
    reply_d        = reply_q;
    rcnt_d         = rcnt_q;
    tmo_d          = tmo_q;
    terr_d         = terr_q;
    s0_waitrequest = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (s0_write || s0_read) begin
          frame_d   = {s0_write, s0_address[30:0], s0_write ? s0_writedata : 32'h0};
          tx_sh_d   = {1'b1, frame_d[63:56], 1'b0};
          tx_div_d  = '0;
          tx_bit_d  = 4'd0;
          tx_byte_d = 3'd0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_div_q == DIV_LAST) begin
          tx_div_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = 4'd0;
            if (tx_byte_q == 3'd7) begin
              rcnt_d  = 2'd0;
              tmo_d   = '0;
              state_d = S_RECV;
            end else begin
              tx_byte_d = tx_byte_q + 3'd1;
              frame_d   = frame_q << 8;
              tx_sh_d   = {1'b1, frame_q[55:48], 1'b0};
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_sh_d  = {1'b1, tx_sh_q[9:1]};
          end
        end else begin
          tx_div_d = tx_div_q + DW'(1);
        end
      end
      S_RECV: begin
        tmo_d = tmo_q + TW'(1);
        if (rx_byte_vld) begin
          reply_d = {reply_q[23:0], rx_sh_q};
          rcnt_d  = rcnt_q + 2'd1;
          if (rcnt_q == 2'd3) state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          terr_d  = 1'b1;
          reply_d = 32'hFFFF_FFFF;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        s0_waitrequest = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    tx_d = (state_d == S_SEND) ? tx_sh_d[0] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      tx_sh_q   <= '1;
      tx_q      <= 1'b1;
      tx_div_q  <= '0;
      tx_bit_q  <= '0;
      tx_byte_q <= '0;
      reply_q   <= '0;
      rcnt_q    <= '0;
      tmo_q     <= '0;
      terr_q    <= 1'b0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_busy_q <= 1'b0;
      rx_div_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      tx_sh_q   <= tx_sh_d;
      tx_q      <= tx_d;
      tx_div_q  <= tx_div_d;
      tx_bit_q  <= tx_bit_d;
      tx_byte_q <= tx_byte_d;
      reply_q   <= reply_d;
      rcnt_q    <= rcnt_d;
      tmo_q     <= tmo_d;
      terr_q    <= terr_d;
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_prev_q <= rx_prev_d;
      rx_busy_q <= rx_busy_d;
      rx_div_q  <= rx_div_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
    end
  end

  assign tx_out      = tx_q;
  assign s0_readdata = reply_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_uart_avalon_master_bridge.sv
// Testbench for uart_avalon_master_bridge: table-driven transfers, reset-in-flight sequence, random transfers.
// Latency: checks the request frame cycle-exactly from the first cycle after acceptance.
// Backpressure: holds s0_read/s0_write until waitrequest is seen low.
module tb_uart_avalon_master_bridge;
  localparam int D   = 4;
  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s0_address, s0_writedata, s0_readdata;
  logic        s0_read, s0_write, s0_waitrequest;
  logic        tx_out, rx_in, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_tmo_err = 1'b0;

  always #5 clk = ~clk;

  uart_avalon_master_bridge #(.DIVIDER(D), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_readdata(s0_readdata),
    .s0_waitrequest(s0_waitrequest), .tx_out(tx_out), .rx_in(rx_in),
    .timeout_err(timeout_err)
  );

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] reply;
    bit          bad_first;
    bit          stray;
    bit          glitch;
    bit          tmo;
    logic [63:0] exp_frame;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference request frame built directly from the frame layout rules.
  function automatic logic [63:0] frame_of(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    logic [63:0] f;
    f[63]    = wr;
    f[62:32] = addr[30:0];
    f[31:0]  = wr ? data : 32'h0;
    return f;
  endfunction

  // Drive one 8N1 byte on rx_in; called on a falling edge.
  task automatic rx_send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      repeat (D) @(negedge clk);
    end
    rx_in = 1'b1;
  endtask

  task automatic run_transfer(input vec_t v, input string tag);
    bit          wave[80];
    int          tx_err;
    int          cyc;
    bit          found;
    logic [31:0] rdat;
    logic        wr_after;
    logic [63:0] f;
    f = v.exp_frame;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = f[63-8*i -: 8];
      wave[10*i] = 1'b0;
      for (int j = 0; j < 8; j++) wave[10*i+1+j] = b[j];
      wave[10*i+9] = 1'b1;
    end
    s0_address = v.addr; s0_writedata = v.data; s0_write = v.wr; s0_read = v.rd;
    tx_err = 0;
    fork
      begin
        for (int c = 0; c < 80*D; c++) begin
          @(negedge clk);
          // Inputs may wander while the frame is in flight; the frame must not change.
          if (c == 3) begin s0_address = $urandom; s0_writedata = $urandom; end
          if (tx_out !== wave[c/D] || s0_waitrequest !== 1'b1) tx_err++;
        end
      end
      begin
        if (v.stray) begin
          repeat (60) @(negedge clk);
          rx_send_byte(8'h55, 1'b1);
        end
      end
    join
    chk({tag, " tx_frame"}, 64'(tx_err), 64'd0);

    found = 1'b0; cyc = 0; rdat = 'x; wr_after = 'x;
    fork
      begin
        if (v.glitch) begin
          @(negedge clk); rx_in = 1'b0;
          @(negedge clk); rx_in = 1'b1;
          repeat (4) @(negedge clk);
        end
        if (!v.tmo) begin
          if (v.bad_first) begin
            rx_send_byte(8'($urandom), 1'b0);
            repeat (3) @(negedge clk);
          end
          for (int i = 0; i < 4; i++) begin
            rx_send_byte(v.reply[31-8*i -: 8], 1'b1);
            repeat ($urandom_range(1, 4)) @(negedge clk);
          end
        end
      end
      begin
        while (!found && cyc < TMO + 400) begin
          @(negedge clk);
          cyc++;
          if (s0_waitrequest === 1'b0) begin
            found = 1'b1;
            rdat = s0_readdata;
            s0_read = 1'b0; s0_write = 1'b0;
          end
        end
        @(negedge clk);
        wr_after = s0_waitrequest;
      end
    join
    s0_read = 1'b0; s0_write = 1'b0;
    if (v.tmo) exp_tmo_err = 1'b1;
    chk({tag, " completion"}, 64'(found), 64'd1);
    chk({tag, " readdata"}, 64'(rdat), 64'(v.exp_rdata));
    chk({tag, " waitreq_high_after"}, 64'(wr_after), 64'd1);
    if (v.tmo) chk({tag, " timeout_cycle"}, 64'(cyc), 64'(TMO + 1));
    chk({tag, " timeout_err"}, 64'(timeout_err), 64'(exp_tmo_err));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vec_t v;
    tbl[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0,
               64'h8000_0010_DEAD_BEEF, 32'hFFFF_FFFF};
    tbl[1] = '{1'b0, 1'b1, 32'h8000_0024, 32'h1111_1111, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0,
               64'h0000_0024_0000_0000, 32'h1234_5678};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0001, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0,
               64'h8000_0001_0000_00A5, 32'hFFFF_FFFF};
    tbl[3] = '{1'b0, 1'b1, 32'h0000_0044, 32'h0, 32'h0102_0304, 1'b1, 1'b0, 1'b1, 1'b0,
               64'h0000_0044_0000_0000, 32'h0102_0304};
    tbl[4] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1,
               64'h0000_0008_0000_0000, 32'hFFFF_FFFF};

    reset = 1'b1; rx_in = 1'b1;
    s0_address = '0; s0_writedata = '0; s0_read = 1'b0; s0_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx_out", 64'(tx_out), 64'd1);
    chk("reset waitrequest", 64'(s0_waitrequest), 64'd1);
    chk("reset readdata", 64'(s0_readdata), 64'd0);
    chk("reset timeout_err", 64'(timeout_err), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_transfer(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of request byte 3.
    s0_address = 32'h0000_0030; s0_read = 1'b1;
    repeat (3*10*D + 5) @(negedge clk);
    reset = 1'b1; s0_read = 1'b0;
    @(negedge clk);
    chk("midreset tx_out", 64'(tx_out), 64'd1);
    chk("midreset waitrequest", 64'(s0_waitrequest), 64'd1);
    chk("midreset timeout_err", 64'(timeout_err), 64'd0);
    exp_tmo_err = 1'b0;
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || s0_waitrequest !== 1'b1) bad++;
    end
    chk("midreset quiet", 64'(bad), 64'd0);
    v = '{1'b0, 1'b1, 32'h0000_0030, 32'h0, 32'hA0B1_C2D3, 1'b0, 1'b0, 1'b0, 1'b0,
          frame_of(1'b0, 32'h0000_0030, 32'h0), 32'hA0B1_C2D3};
    run_transfer(v, "post_reset");

    for (int n = 0; n < 8; n++) begin
      v.wr        = 1'($urandom_range(0, 1));
      v.rd        = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      v.addr      = $urandom;
      v.data      = $urandom;
      v.reply     = $urandom;
      v.bad_first = ($urandom_range(0, 3) == 0);
      v.stray     = 1'($urandom_range(0, 1));
      v.glitch    = 1'($urandom_range(0, 1));
      v.tmo       = 1'b0;
      v.exp_frame = frame_of(v.wr, v.addr, v.data);
      v.exp_rdata = v.reply;
      run_transfer(v, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
